// File: rtl/shift_register_p10.sv
// Serial-in/serial-out delay line: DEPTH rising-edge D flip-flops from sIn to sOut.
// Ports: clk (rising edge), rst (async active-low clear), sIn (serial in), sOut (serial out).
// Latency DEPTH cycles; no flow control, sOut is driven straight from the last register.
module shift_register_p10 #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sIn,
  output logic sOut
);

  logic [DEPTH-1:0] stage;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stage <= '0;
        end else begin
          stage[0] <= sIn;
        end
      end
    end else begin : g_chain
      // stage[0] takes sIn, every other stage takes its predecessor, all at once.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stage <= '0;
        end else begin
          stage <= {stage[DEPTH-2:0], sIn};
        end
      end
    end
  endgenerate

  assign sOut = stage[DEPTH-1];

endmodule

// File: tb/tb_shift_register_p10.sv
`timescale 1ns/1ps
module tb_shift_register_p10;

  localparam int HALF = 600;

  logic clk;
  logic rst;
  logic sIn;
  logic sOut;
  logic sOut1;

  int total;
  int passed;

  logic [3:0] ref4;
  logic       ref1;

  shift_register_p10 #(.DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .sIn  (sIn),
    .sOut (sOut)
  );

  shift_register_p10 #(.DEPTH(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .sIn  (sIn),
    .sOut (sOut1)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One full clock period: rising edge after HALF, falling edge after another HALF.
  task automatic tick();
    #(HALF) clk = 1'b1;
    #(HALF) clk = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] exp_lat;
    total  = 0;
    passed = 0;
    clk = 1'b0;
    rst = 1'b0;
    sIn = 1'b0;
    #10;
    check("reset_state", sOut, 1'b0);

    // Fill with ones, then clear asynchronously between edges.
    rst = 1'b1;
    sIn = 1'b1;
    tick(); tick(); tick();
    check("fill_edge3", sOut, 1'b0);
    tick();
    check("fill_edge4", sOut, 1'b1);
    #100 rst = 1'b0;
    #1;
    check("async_clear", sOut, 1'b0);
    tick(); tick();
    check("edges_ignored_in_reset", sOut, 1'b0);

    // Latency: 1,0,1,1,0,0,0,0 -> sOut after edges 1..8 = 0,0,0,1,0,1,1,0.
    rst = 1'b1;
    pat     = 8'b0000_1101;  // bit i drives edge i+1
    exp_lat = 8'b0110_1000;  // bit i expected after edge i+1
    for (int i = 0; i < 8; i++) begin
      sIn = pat[i];
      tick();
      check($sformatf("latency_edge%0d", i + 1), sOut, exp_lat[i]);
    end

    // sIn toggles while clk is high or low must not matter; only the rising edge samples.
    for (int i = 0; i < 4; i++) begin
      sIn = 1'b1;
      #(HALF) clk = 1'b1;
      #5;
      check($sformatf("fe_rise%0d", i + 1), sOut, (i == 3) ? 1'b1 : 1'b0);
      sIn = 1'b0;
      #100;
      check($sformatf("fe_high_toggle%0d", i + 1), sOut, (i == 3) ? 1'b1 : 1'b0);
      #(HALF - 105) clk = 1'b0;
      #5;
      check($sformatf("fe_fall%0d", i + 1), sOut, (i == 3) ? 1'b1 : 1'b0);
      sIn = 1'b1;
      #10 sIn = 1'b0;
      #(HALF - 15);
      clk = 1'b0;
    end
    // Pulses between edges are never captured: ones drain out.
    for (int i = 0; i < 4; i++) begin
      sIn = 1'b0;
      #(HALF/2) sIn = 1'b1;
      #20 sIn = 1'b0;
      #(HALF - HALF/2 - 20) clk = 1'b1;
      #(HALF/2) sIn = 1'b1;
      #20 sIn = 1'b0;
      #(HALF - HALF/2 - 20) clk = 1'b0;
      check($sformatf("pulse_drain%0d", i + 1), sOut, (i == 3) ? 1'b0 : 1'b1);
    end

    // Late change 10 ns before the rising edge is captured.
    sIn = 1'b0;
    #(HALF - 10) sIn = 1'b1;
    #10 clk = 1'b1;
    #(HALF) clk = 1'b0;
    sIn = 1'b0;
    tick(); tick();
    check("late_edge3", sOut, 1'b0);
    tick();
    check("late_edge4", sOut, 1'b1);
    tick();
    check("late_edge5", sOut, 1'b0);

    // Mid-stream reset discards in-flight ones.
    sIn = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("mid_reset_assert", sOut, 1'b0);
    #(2000 - 1);
    check("mid_reset_hold", sOut, 1'b0);
    while (clk !== 1'b0) #1;
    #100 rst = 1'b1;
    sIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid_reset_after%0d", i + 1), sOut, 1'b0);
    end

    // Random stream with occasional reset pulses against a reference delay model.
    ref4 = 4'b0000;
    ref1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 13 || i == 29) begin
        rst = 1'b0;
        #50;
        ref4 = 4'b0000;
        ref1 = 1'b0;
        check($sformatf("rnd_reset%0d", i), sOut, 1'b0);
        check($sformatf("rnd_reset_d1_%0d", i), sOut1, 1'b0);
        rst = 1'b1;
      end
      sIn = 1'($urandom_range(0, 1));
      ref4 = {ref4[2:0], sIn};
      ref1 = sIn;
      tick();
      check($sformatf("rnd_d4_%0d", i), sOut, ref4[3]);
      check($sformatf("rnd_d1_%0d", i), sOut1, ref1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
